// File: rtl/pc_gen.sv
// pc_gen: prefetch-stage next-PC generator.
// Owns the fetch PC, issues icache requests and feeds the fetch PC to the BPU.
// The delay slot of a predicted-taken branch is always fetched before the
// redirect to the predicted target. If that delay-slot fetch is stalled, the
// target is parked in held_target and the FSM waits in DS.
// Optional feature macro: PCGEN_ADEL_CHECK_EN.
//   Defined   : fetch_adel / fetch_badvaddr ports exist. A misaligned PC blocks
//               requests until the next pipeline flush.
//   Undefined : neither port exists, and inst_addr[1:0] is forced to 2'b00.
module pc_gen #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipeline_flush,
  input  logic [ADDR_W-1:0] flush_target,
  input  logic              bpu_idle,
  input  logic [ADDR_W-1:0] correction_target,
  input  logic              pred_valid,
  input  logic              pred_br_op,
  input  logic              pred_br_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic              fifo_full,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  output logic              inst_is_ds,
  output logic              fetch_to_bpu_valid,
`ifdef PCGEN_ADEL_CHECK_EN
  output logic              fetch_adel,
  output logic [ADDR_W-1:0] fetch_badvaddr,
`endif
  output logic [ADDR_W-1:0] fetch_to_bpu_pc
);

  typedef enum logic {
    SEQ = 1'b0,
    DS  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] held_target;
  logic [ADDR_W-1:0] held_next;
  logic              last_acc;
  logic              last_acc_next;
  logic              last_ds;
  logic              last_ds_next;
  logic              accept;
  logic              usable;
  logic              req_block;

`ifdef PCGEN_ADEL_CHECK_EN
  logic              adel;
  logic [ADDR_W-1:0] bad_addr;
  logic              misaligned;

  // Misalignment is flagged as soon as the PC goes bad, then latched until a flush
  always_comb begin
    misaligned     = (pc[1:0] != 2'b00);
    fetch_adel     = adel || misaligned;
    fetch_badvaddr = adel ? bad_addr : pc;
    req_block      = fetch_adel;
  end

  // Sticky address-error record, cleared only by a pipeline flush
  always_ff @(posedge clk) begin
    if (reset) begin
      adel     <= 1'b0;
      bad_addr <= {ADDR_W{1'b0}};
    end else if (pipeline_flush) begin
      adel     <= 1'b0;
      bad_addr <= {ADDR_W{1'b0}};
    end else if (misaligned && !adel) begin
      adel     <= 1'b1;
      bad_addr <= pc;
    end else begin
      adel     <= adel;
      bad_addr <= bad_addr;
    end
  end
`else
  // Without the address-error check, nothing blocks a request
  always_comb begin
    req_block = 1'b0;
  end
`endif

  // Request, handshake and delay-slot qualification
  always_comb begin
    inst_req = !fifo_full && !reset && !req_block;
`ifdef PCGEN_ADEL_CHECK_EN
    inst_addr = pc;
`else
    inst_addr = {pc[ADDR_W-1:2], 2'b00};
`endif
    accept             = inst_req && inst_addr_ok;
    fetch_to_bpu_valid = accept;
    fetch_to_bpu_pc    = inst_addr;
    // A prediction is only trusted for the fetch accepted just before, when
    // that fetch was not itself a delay slot and no target is already pending.
    usable = pred_valid && pred_br_op && pred_br_taken &&
             last_acc && !last_ds && (state == SEQ);
    inst_is_ds = !reset && ((state == DS) || usable);
  end

  // Next-PC selection: flush > correction > usable prediction > pending target > sequential
  always_comb begin
    pc_next       = pc;
    state_next    = state;
    held_next     = held_target;
    last_acc_next = accept;
    last_ds_next  = accept && inst_is_ds;
    if (pipeline_flush) begin
      pc_next       = flush_target;
      state_next    = SEQ;
      last_acc_next = 1'b0;
      last_ds_next  = 1'b0;
    end else if (!bpu_idle) begin
      pc_next       = correction_target;
      state_next    = SEQ;
      last_acc_next = 1'b0;
      last_ds_next  = 1'b0;
    end else if (usable) begin
      if (accept) begin
        pc_next = pred_target;
      end else begin
        held_next  = pred_target;
        state_next = DS;
      end
    end else if ((state == DS) && accept) begin
      pc_next    = held_target;
      state_next = SEQ;
    end else if (accept) begin
      pc_next = pc + ADDR_W'(4);
    end else begin
      pc_next = pc;
    end
  end

  // State, PC and fetch-history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= SEQ;
      held_target <= {ADDR_W{1'b0}};
      last_acc    <= 1'b0;
      last_ds     <= 1'b0;
    end else begin
      pc          <= pc_next;
      state       <= state_next;
      held_target <= held_next;
      last_acc    <= last_acc_next;
      last_ds     <= last_ds_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen.
// The driver applies inputs on the falling edge and runs a fetch-stream model.
// Each expected accepted fetch (address, delay-slot flag) is pushed to a queue.
// The monitor samples shortly after the falling edge and pops one entry for
// every fetch the DUT accepts. Directed segments follow the test plan; a long
// random run follows them.
module tb_pc_gen;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipeline_flush = 1'b0;
  logic [31:0] flush_target = 32'h0;
  logic        bpu_idle = 1'b1;
  logic [31:0] correction_target = 32'h0;
  logic        pred_valid = 1'b0;
  logic        pred_br_op = 1'b0;
  logic        pred_br_taken = 1'b0;
  logic [31:0] pred_target = 32'h0;
  logic        fifo_full = 1'b0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_is_ds;
  logic        fetch_to_bpu_valid;
  logic [31:0] fetch_to_bpu_pc;
`ifdef PCGEN_ADEL_CHECK_EN
  logic        fetch_adel;
  logic [31:0] fetch_badvaddr;
`endif

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .pipeline_flush(pipeline_flush),
    .flush_target(flush_target), .bpu_idle(bpu_idle),
    .correction_target(correction_target), .pred_valid(pred_valid),
    .pred_br_op(pred_br_op), .pred_br_taken(pred_br_taken),
    .pred_target(pred_target), .fifo_full(fifo_full),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_is_ds(inst_is_ds), .fetch_to_bpu_valid(fetch_to_bpu_valid),
`ifdef PCGEN_ADEL_CHECK_EN
    .fetch_adel(fetch_adel), .fetch_badvaddr(fetch_badvaddr),
`endif
    .fetch_to_bpu_pc(fetch_to_bpu_pc)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        ds;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] acc_log[$];

  // Model of the fetch stream.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_owed;
  bit          m_prev_plain;
  bit          m_adel;
  bit          exp_req;
  logic [31:0] exp_addr;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the model's view of that cycle.
  task automatic cyc(input bit rst, input bit fl, input logic [31:0] ft,
                     input bit idle, input logic [31:0] ct,
                     input bit pv, input bit pb, input bit pk, input logic [31:0] ptg,
                     input bit ff, input bit ok);
    bit req, acc, use_pred, ds;
    @(negedge clk);
    reset = rst; pipeline_flush = fl; flush_target = ft; bpu_idle = idle;
    correction_target = ct; pred_valid = pv; pred_br_op = pb; pred_br_taken = pk;
    pred_target = ptg; fifo_full = ff; inst_addr_ok = ok;
    if (rst) begin
      exp_req = 1'b0;
      m_pc = RESET_PC; m_tgt = 32'h0; m_owed = 0; m_prev_plain = 0; m_adel = 0;
    end else begin
      req = !ff;
`ifdef PCGEN_ADEL_CHECK_EN
      if (m_adel || (m_pc[1:0] != 2'b00)) req = 1'b0;
      exp_addr = m_pc;
`else
      exp_addr = m_pc & 32'hFFFF_FFFC;
`endif
      exp_req  = req;
      acc      = req && ok;
      use_pred = pv && pb && pk && m_prev_plain && !m_owed;
      ds       = m_owed || use_pred;
      if (acc) sb.push_back('{addr: exp_addr, ds: ds});
`ifdef PCGEN_ADEL_CHECK_EN
      if (fl) m_adel = 0;
      else if (m_pc[1:0] != 2'b00) m_adel = 1;
`endif
      if (fl) begin
        m_pc = ft; m_owed = 0;
      end else if (!idle) begin
        m_pc = ct; m_owed = 0;
      end else if (use_pred) begin
        if (acc) m_pc = ptg;
        else begin m_tgt = ptg; m_owed = 1; end
      end else if (m_owed && acc) begin
        m_pc = m_tgt; m_owed = 0;
      end else if (acc) begin
        m_pc = m_pc + 32'd4;
      end
      m_prev_plain = (fl || !idle) ? 1'b0 : (acc && !ds);
    end
  endtask

  task automatic plain(input bit ok);
    cyc(0, 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 0, ok);
  endtask

  task automatic pred(input logic [31:0] t, input bit ok);
    cyc(0, 0, 32'h0, 1, 32'h0, 1, 1, 1, t, 0, ok);
  endtask

  task automatic do_reset();
    cyc(1, 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    cyc(1, 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    #2;
    acc_log.delete();
  endtask

  // Compare the DUT's accepted-address history with a fixed list.
  task automatic check_log(input string name, input logic [31:0] e[$]);
    #2;
    chk(acc_log.size() == e.size(), name, 32'(acc_log.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < acc_log.size(); i++)
      chk(acc_log[i] == e[i], name, acc_log[i], e[i]);
  endtask

  // Monitor: pop and compare on every accepted fetch.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      chk(inst_req == exp_req, "inst_req", 32'(inst_req), 32'(exp_req));
      chk(inst_addr == exp_addr, "inst_addr", inst_addr, exp_addr);
      chk(fetch_to_bpu_pc == exp_addr, "bpu_pc", fetch_to_bpu_pc, exp_addr);
      if (fetch_to_bpu_valid) begin
        acc_log.push_back(inst_addr);
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_accept", inst_addr, 32'h0);
        end else begin
          e = sb.pop_front();
          chk(inst_addr == e.addr, "accept_addr", inst_addr, e.addr);
          chk(inst_is_ds == e.ds, "accept_ds", 32'(inst_is_ds), 32'(e.ds));
        end
      end
      chk(sb.size() == 0, "missed_accept", 32'(sb.size()), 32'h0);
      if (sb.size() != 0) sb.delete();
    end else begin
      chk(inst_req == 1'b0, "reset_req", 32'(inst_req), 32'h0);
    end
  end

  initial begin
    logic [31:0] e[$];
    do_reset();
    // Sequential fetch from the reset vector
    plain(1); plain(1); plain(1);
    e = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
    check_log("seq", e);

    // Taken prediction while the delay slot is accepted
    do_reset();
    plain(1); pred(32'h8000_1000, 1); plain(1);
    e = '{32'hBFC0_0000, 32'hBFC0_0004, 32'h8000_1000};
    check_log("pred_acc", e);

    // Taken prediction with the delay slot stalled for three cycles
    do_reset();
    plain(1); pred(32'h8000_1000, 0); plain(0); plain(0); plain(1); plain(1);
    e = '{32'hBFC0_0000, 32'hBFC0_0004, 32'h8000_1000};
    check_log("pred_ds", e);

    // Correction while in DS drops the pending target; the next prediction is stale
    do_reset();
    plain(1); pred(32'h8000_1000, 0);
    cyc(0, 0, 32'h0, 0, 32'h8000_2000, 0, 0, 0, 32'h0, 0, 0);
    pred(32'h8000_3000, 1); plain(1);
    e = '{32'hBFC0_0000, 32'h8000_2000, 32'h8000_2004};
    check_log("corr", e);

    // Flush, correction and prediction together: flush wins
    do_reset();
    plain(1);
    cyc(0, 1, 32'hBFC0_0380, 0, 32'h8000_2000, 1, 1, 1, 32'h8000_1000, 0, 1);
    plain(1);
    e = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0380};
    check_log("flush", e);

    // fifo_full stall mid-stream
    do_reset();
    plain(1); plain(1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 1, 1);
    plain(1); plain(1);
    e = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C};
    check_log("stall", e);

`ifdef PCGEN_ADEL_CHECK_EN
    // A misaligned flush target raises an address error and blocks requests
    do_reset();
    plain(1);
    cyc(0, 1, 32'h8000_0002, 1, 32'h0, 0, 0, 0, 32'h0, 0, 1);
    plain(1); #2;
    chk(fetch_adel == 1'b1, "adel", 32'(fetch_adel), 32'h1);
    chk(fetch_badvaddr == 32'h8000_0002, "badvaddr", fetch_badvaddr, 32'h8000_0002);
    plain(1); #2;
    chk(fetch_adel == 1'b1, "adel_hold", 32'(fetch_adel), 32'h1);
    cyc(0, 1, 32'h8000_0100, 1, 32'h0, 0, 0, 0, 32'h0, 0, 1);
    plain(1); #2;
    chk(fetch_adel == 1'b0, "adel_clear", 32'(fetch_adel), 32'h0);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r  = ($urandom_range(99) < 1);
      bit fl = ($urandom_range(99) < 3);
      bit co = ($urandom_range(99) < 4);
      bit pv = ($urandom_range(99) < 40);
      cyc(r, fl, $urandom() & 32'hFFFF_FFFC, !co, $urandom() & 32'hFFFF_FFFC,
          pv, pv || ($urandom_range(3) == 0), ($urandom_range(99) < 70),
          $urandom() & 32'hFFFF_FFFC,
          ($urandom_range(99) < 20), ($urandom_range(99) < 70));
    end
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Prefetch-stage next-PC generator.
- Owns the fetch PC and issues instruction requests to the icache.
- Drives the fetch PC to the BPU.
- Consumes the BPU's registered prediction, its correction redirect and its idle flag, plus the pipeline flush target.
- Guarantees the MIPS delay slot of a predicted-taken branch is fetched before redirecting to the target.

Parameters:
- RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset.
- ADDR_W, 32, virtual address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pipeline_flush  in  1  exception/eret flush
- flush_target  in  ADDR_W  PC after flush
- bpu_idle  in  1  BPU state==IDLE; 0 means correction active this cycle
- correction_target  in  ADDR_W  redirect PC, valid when bpu_idle=0
- pred_valid  in  1  prediction qualifier
- pred_br_op  in  1  predicted instruction is a branch
- pred_br_taken  in  1  predicted taken
- pred_target  in  ADDR_W  predicted target
- fifo_full  in  1  downstream inst buffer full
- inst_req  out  1  icache request
- inst_addr  out  ADDR_W  request address
- inst_addr_ok  in  1  icache accepts request
- inst_is_ds  out  1  request is a predicted delay slot
- fetch_to_bpu_valid  out  1  equals accept
- fetch_to_bpu_pc  out  ADDR_W  equals inst_addr

Behaviour:
- accept = inst_req && inst_addr_ok.
- inst_req = ~fifo_full && ~reset; inst_addr = pc.
- Reset values: pc=RESET_PC, state=SEQ, held_target=0, last_acc=0, last_ds=0, inst_is_ds=0.
- last_acc/last_ds register, each cycle, whether an accept occurred and its inst_is_ds. Both are forced to 0 in any cycle that applies a redirect (flush or correction).
- A prediction is usable iff pred_valid && pred_br_op && pred_br_taken && last_acc && ~last_ds && state==SEQ. Predictions for delay-slot fetches or stale fetches are discarded.
- Next-PC priority, evaluated per cycle:
  1. reset.
  2. pipeline_flush: pc<=flush_target, state<=SEQ.
  3. ~bpu_idle: pc<=correction_target, state<=SEQ.
  4. Usable prediction. The current pc is P+4, the delay slot of branch P.
     - If accept this cycle: pc<=pred_target, state stays SEQ.
     - Else: held_target<=pred_target, state<=DS.
  5. state==DS and accept: pc<=held_target, state<=SEQ.
  6. accept: pc<=pc+4.
  7. Otherwise pc holds.
- inst_is_ds=1 when state==DS, and in the usable-prediction cycle (combinational).
- FSM:
  - SEQ -> DS on a usable prediction without accept.
  - DS -> SEQ on accept, flush or correction.
- Redirect cycles still issue the old pc if accepted. Downstream squashes using the flush/correction signals.
- pc+4 wraps modulo 2^ADDR_W.
- fifo_full masks inst_req only; state and pending target are retained.
- Flush and correction in the same cycle: flush wins.

Optional Feature:
- PCGEN_ADEL_CHECK_EN.
- Defined:
  - Output fetch_adel (1 bit) and output fetch_badvaddr (ADDR_W).
  - If pc[1:0]!=0, inst_req is forced 0, fetch_adel=1 and fetch_badvaddr=pc.
  - These hold until a flush.
- Undefined:
  - Neither port exists.
  - inst_addr[1:0] is forced to 2'b00.

Test Plan:
- Reset, then inst_addr_ok=1 constantly -> inst_addr sequence BFC00000, BFC00004, BFC00008; fetch_to_bpu_valid=1 each cycle.
- Prediction taken, target 0x80001000, arrives while 0xBFC00004 is accepted -> next inst_addr=0x80001000, inst_is_ds=1 on 0xBFC00004.
- Same prediction, but inst_addr_ok=0 for 3 cycles -> state DS; 0xBFC00004 is held and then accepted, then 0x80001000; no 0xBFC00008 issued.
- bpu_idle=0 with correction_target=0x80002000 while in DS -> next pc=0x80002000, state SEQ, pending target dropped. A taken prediction in the following cycle is ignored (last_acc=0).
- pipeline_flush with flush_target=0xBFC00380 in the same cycle as bpu_idle=0 and a taken prediction -> pc=0xBFC00380.
- fifo_full=1 for 4 cycles mid-stream -> inst_req=0 and pc constant; resumes at the same pc. Under PCGEN_ADEL_CHECK_EN, flush_target=0x80000002 -> fetch_adel=1, fetch_badvaddr=0x80000002, no request issued.
